hamming_512b_decoder: RTL

SECDED decoder for 512-bit cache-line data protected by the 523-bit extended Hamming codeword (`hamming_512b_t`). It checks a stored codeword read from a cache data array and corrects any single-bit error. It flags double-bit and out-of-range errors as uncorrectable. It sits on the read path between the data SRAM output and the line consumer, is a two-stage pipeline, and keeps saturating error-event counters for software-visible ECC statistics.

---
 rtl/hamming_512b_decoder_pkg.sv | 32 +++
 rtl/hamming_512b_decoder_syndrome.sv | 22 ++
 rtl/hamming_512b_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/hamming_512b_decoder_pkg.sv
// Shared types for the 512-bit SECDED read path.
// Codeword layout, status encoding and the data-extraction helper.
package defines;

    localparam int HAMMING_512B_CW_BITS = 523;
    localparam int CACHE_LINE_BITS      = 512;

    typedef logic [HAMMING_512B_CW_BITS-1:0] hamming_512b_t;
    typedef logic [CACHE_LINE_BITS-1:0]      cache_line_data_t;

    typedef enum logic [1:0] {
        ECC_NONE          = 2'd0,
        ECC_CORRECTED     = 2'd1,
        ECC_UNCORRECTABLE = 2'd2
    } ecc_status_t;

    // Data bits occupy every index whose Hamming position is not a power of two.
    function automatic cache_line_data_t extract_data(input hamming_512b_t cw);
        cache_line_data_t d;
        int j;
        d = '0;
        j = 0;
        for (int i = 0; i < HAMMING_512B_CW_BITS - 1; i++) begin
            if (((i + 1) & i) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_512b_decoder_syndrome.sv
// Combinational syndrome and overall-parity generator for the 523-bit codeword.
// Kept standalone so scrub logic can reuse it.
module hamming_512b_syndrome
    import defines::*;
(
    input  hamming_512b_t coded_word,
    output logic [9:0]    syndrome,
    output logic          parity
);

    always_comb begin
        syndrome = '0;
        for (int i = 0; i < HAMMING_512B_CW_BITS - 1; i++) begin
            for (int k = 0; k < 10; k++) begin
                if (((i + 1) >> k) & 1)
                    syndrome[k] = syndrome[k] ^ coded_word[i];
            end
        end
        parity = ^coded_word;
    end

endmodule

// File: rtl/hamming_512b_decoder.sv
// Two-stage SECDED decoder for 512-bit cache lines with saturating error counters.
// Counters are built only when HAMMING_ERR_COUNTERS_EN is defined.
module hamming_512b_decoder
    import defines::*;
#(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid_in,
    input  hamming_512b_t            coded_word,
    output logic                     dec_valid_out,
    output cache_line_data_t         decoded_word,
    output ecc_status_t              ecc_status,
    output logic [9:0]               err_position,
    input  logic                     count_clear,
    output logic [COUNTER_WIDTH-1:0] corrected_count,
    output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

    logic [9:0]    syn;
    logic          par;
    logic          v1;
    logic [9:0]    s1;
    logic          p1;
    hamming_512b_t cw1;

    hamming_512b_syndrome u_syndrome (
        .coded_word (coded_word),
        .syndrome   (syn),
        .parity     (par)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            s1  <= '0;
            p1  <= 1'b0;
            cw1 <= '0;
        end else begin
            v1 <= dec_valid_in;
            if (dec_valid_in) begin
                s1  <= syn;
                p1  <= par;
                cw1 <= coded_word;
            end
        end
    end

    ecc_status_t   st;
    logic [9:0]    pos;
    hamming_512b_t fixed;
    logic          s_zero;
    logic          s_in_range;

    assign s_zero     = (s1 == 10'd0);
    assign s_in_range = (s1 <= 10'd522);

    always_comb begin
        st    = ECC_NONE;
        pos   = '0;
        fixed = cw1;
        unique case (1'b1)
            !p1 && s_zero: st = ECC_NONE;
            !p1 && !s_zero: st = ECC_UNCORRECTABLE;
            p1 && s_zero: begin
                // Only the overall parity bit flipped; data is untouched.
                st  = ECC_CORRECTED;
                pos = 10'd522;
            end
            p1 && !s_zero && s_in_range: begin
                st    = ECC_CORRECTED;
                pos   = s1 - 10'd1;
                fixed = cw1 ^ (hamming_512b_t'(1) << pos);
            end
            default: st = ECC_UNCORRECTABLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_valid_out <= 1'b0;
            decoded_word  <= '0;
            ecc_status    <= ECC_NONE;
            err_position  <= '0;
        end else begin
            dec_valid_out <= v1;
            if (v1) begin
                decoded_word <= extract_data(fixed);
                ecc_status   <= st;
                err_position <= pos;
            end
        end
    end

`ifdef HAMMING_ERR_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            corrected_count     <= '0;
            uncorrectable_count <= '0;
        end else if (count_clear) begin
            corrected_count     <= '0;
            uncorrectable_count <= '0;
        end else if (dec_valid_out) begin
            if (ecc_status == ECC_CORRECTED && corrected_count != '1)
                corrected_count <= corrected_count + 1'b1;
            if (ecc_status == ECC_UNCORRECTABLE && uncorrectable_count != '1)
                uncorrectable_count <= uncorrectable_count + 1'b1;
        end
    end
`else
    logic unused_count_clear;
    assign unused_count_clear  = count_clear;
    assign corrected_count     = '0;
    assign uncorrectable_count = '0;
`endif

endmodule
